alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one combinational 32-bit alu instance between two requesters, e.g. port 0 = CPU execute stage and port 1 = a DMA/checksum engine.
- Arbitrates between the requesters, registers the operands into the ALU, and registers the result and flags back out.
- Two-stage pipeline with valid/ready handshakes on both the request and response sides; sustains one operation per cycle.

Parameters:
- RR, 1: 1 = round-robin arbitration; 0 = fixed priority, port 0 wins.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req0_valid, req1_valid  in  1  request present on port n.
- req0_ready, req1_ready  out  1  request accepted this cycle on port n.
- req0_a, req1_a  in  32  operand a.
- req0_b, req1_b  in  32  operand b.
- req0_op, req1_op  in  8  ALU opcode, passed through unchanged.
- rsp0_valid, rsp1_valid  out  1  response available for port n.
- rsp0_ready, rsp1_ready  in  1  port n consumes the response.
- rsp_c  out  32  result; shared, qualified by rspN_valid.
- rsp_zero, rsp_neg  out  1  registered is_zero / is_negative.
- alu_a, alu_b  out  32  to ALU operand inputs.
- alu_op  out  8  to ALU op input.
- alu_c  in  32  ALU result.
- alu_zero, alu_neg  in  1  ALU flags.

Behaviour:
- Reset (synchronous, active-high, dominates everything):
  - s1_valid = s2_valid = 0; all req/rsp ready/valid outputs 0.
  - alu_a/alu_b/alu_op/rsp_c = 0; rsp_zero = rsp_neg = 0; last_grant = 1, so port 0 wins first under RR.
  - Reset mid-operation discards in-flight ops with no response.
- Stage 1 (S1) holds a, b, op and owner id. alu_a/alu_b/alu_op are driven directly from S1 registers, so the ALU sees only stable registered inputs.
- Stage 2 (S2) holds c, zero, neg and owner id, captured from the alu_* inputs.
- Response: rsp{owner}_valid = s2_valid; the other port's rsp_valid = 0.
- Drain: s2_drain = s2_valid & rsp{owner}_ready.
- S2 load: s2_load = s1_valid & (~s2_valid | s2_drain).
- S1 advance: s1_adv = s2_load; S1 may accept when ~s1_valid | s1_adv.
- Grant is combinational, computed only when S1 may accept:
  - One valid: grant it.
  - Both valid, RR=1: grant port != last_grant.
  - Both valid, RR=0: grant port 0.
  - reqN_ready = grant_N. Transfer occurs on valid & ready.
  - last_grant updates only on a transfer.
- Latency: accept at cycle T produces rsp valid at T+2 if no stall.
- Throughput: 1 op/cycle with both rsp_ready high.
- Back-pressure:
  - S2 held (owner not ready): S2 contents frozen; S1 holds if full; requests are then refused.
  - Simultaneous S2 drain and S2 load in the same cycle: S2 loads the new result, s2_valid stays 1.
  - Simultaneous S1 advance and new accept: S1 takes the new request.
- Requesters must keep a/b/op stable while valid and not ready. Dropping valid before ready is allowed and is ignored by the arbiter.
- Order: responses are returned in accept order globally. A port whose rsp_ready is low blocks the other port's responses (accepted head-of-line behaviour).
- No opcode decoding. Undefined opcodes return whatever the ALU produces (0).
- rsp_c, rsp_zero, rsp_neg hold their values while s2_valid = 0 after a drain.

Test Plan:
- Single op: port 0, a=5, b=7, op=0, rsp0_ready=1 -> req0_ready at T, rsp0_valid at T+2 with rsp_c=12, zero=0, neg=0; rsp1_valid stays 0.
- Flags: port 1, a=5, b=5, op=2 -> rsp_c=0, zero=1. Then a=3, b=5, op=2 -> rsp_c=0xFFFFFFFE, neg=1.
- Round-robin: both ports valid continuously, 4 ops each, RR=1 -> grants 0,1,0,1,…; responses alternate owner each cycle, 8 results in 9 cycles after the first accept.
- Fixed priority: RR=0, both valid -> port 0 takes every grant; req1_ready stays 0 until req0_valid drops.
- Back-pressure:
  - Port 0 op a=1, b=4, op=12 (shl) with rsp0_ready=0 for 3 cycles, port 1 streaming -> rsp_c=16 held stable, S1 fills, req1_ready=0.
  - Raise rsp0_ready -> rsp0 completes, then port 1 resumes with no op lost or duplicated.
- Reset mid-flight: assert reset with S1 and S2 full -> next cycle all valids/readys 0, no response emitted; a fresh port-0 request is then granted first.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational 32-bit ALU: arbitrated
// S1 operand register, S2 result register, valid/ready on both sides.
module alu_arbiter #(
    parameter bit RR = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req1_a,
    input  logic [31:0] req0_b,
    input  logic [31:0] req1_b,
    input  logic [7:0]  req0_op,
    input  logic [7:0]  req1_op,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    input  logic        rsp0_ready,
    input  logic        rsp1_ready,
    output logic [31:0] rsp_c,
    output logic        rsp_zero,
    output logic        rsp_neg,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [7:0]  alu_op,
    input  logic [31:0] alu_c,
    input  logic        alu_zero,
    input  logic        alu_neg
);

    logic        r_s1_valid;
    logic [31:0] r_s1_a;
    logic [31:0] r_s1_b;
    logic [7:0]  r_s1_op;
    logic        r_s1_owner;

    logic        r_s2_valid;
    logic [31:0] r_s2_c;
    logic        r_s2_zero;
    logic        r_s2_neg;
    logic        r_s2_owner;

    logic        r_last_grant;

    logic [1:0]  w_req_valid;
    logic [1:0]  w_rsp_ready;
    logic [1:0]  w_rsp_valid;
    logic [1:0]  w_grant;
    logic        w_s2_drain;
    logic        w_s2_load;
    logic        w_s1_can_accept;
    logic        w_xfer;

    assign w_req_valid = {req1_valid, req0_valid};
    assign w_rsp_ready = {rsp1_ready, rsp0_ready};

    assign w_s2_drain      = r_s2_valid & w_rsp_ready[r_s2_owner];
    assign w_s2_load       = r_s1_valid & (~r_s2_valid | w_s2_drain);
    assign w_s1_can_accept = ~r_s1_valid | w_s2_load;

    // Grant only ever asserts on a valid port, so any grant is a transfer.
    always_comb begin
        w_grant = 2'b00;
        if (w_s1_can_accept && !reset) begin
            if (w_req_valid == 2'b11) begin
                if (RR && (r_last_grant == 1'b0)) begin
                    w_grant = 2'b10;
                end else begin
                    w_grant = 2'b01;
                end
            end else begin
                w_grant = w_req_valid;
            end
        end
    end

    assign w_xfer = |w_grant;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign w_rsp_valid[gi] = r_s2_valid & (r_s2_owner == 1'(gi));
        end
    endgenerate

    assign req0_ready = w_grant[0];
    assign req1_ready = w_grant[1];
    assign rsp0_valid = w_rsp_valid[0];
    assign rsp1_valid = w_rsp_valid[1];

    assign alu_a  = r_s1_a;
    assign alu_b  = r_s1_b;
    assign alu_op = r_s1_op;

    assign rsp_c    = r_s2_c;
    assign rsp_zero = r_s2_zero;
    assign rsp_neg  = r_s2_neg;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid   <= 1'b0;
            r_s1_a       <= '0;
            r_s1_b       <= '0;
            r_s1_op      <= '0;
            r_s1_owner   <= 1'b0;
            r_s2_valid   <= 1'b0;
            r_s2_c       <= '0;
            r_s2_zero    <= 1'b0;
            r_s2_neg     <= 1'b0;
            r_s2_owner   <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            if (w_xfer) begin
                r_s1_valid   <= 1'b1;
                r_s1_a       <= w_grant[1] ? req1_a  : req0_a;
                r_s1_b       <= w_grant[1] ? req1_b  : req0_b;
                r_s1_op      <= w_grant[1] ? req1_op : req0_op;
                r_s1_owner   <= w_grant[1];
                r_last_grant <= w_grant[1];
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end

            // Result fields are left untouched on a plain drain so the
            // last response stays visible.
            if (w_s2_load) begin
                r_s2_valid <= 1'b1;
                r_s2_c     <= alu_c;
                r_s2_zero  <= alu_zero;
                r_s2_neg   <= alu_neg;
                r_s2_owner <= r_s1_owner;
            end else if (w_s2_drain) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench: one round-robin and one fixed-priority instance share the
// request/response stimulus; each has its own behavioural ALU.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_a, req1_a, req0_b, req1_b;
    logic [7:0]  req0_op, req1_op;
    logic        rsp0_ready, rsp1_ready;

    logic        rr_req0_ready, rr_req1_ready, rr_rsp0_valid, rr_rsp1_valid;
    logic [31:0] rr_rsp_c, rr_alu_a, rr_alu_b, rr_alu_c;
    logic        rr_rsp_zero, rr_rsp_neg, rr_alu_zero, rr_alu_neg;
    logic [7:0]  rr_alu_op;

    logic        fp_req0_ready, fp_req1_ready, fp_rsp0_valid, fp_rsp1_valid;
    logic [31:0] fp_rsp_c, fp_alu_a, fp_alu_b, fp_alu_c;
    logic        fp_rsp_zero, fp_rsp_neg, fp_alu_zero, fp_alu_neg;
    logic [7:0]  fp_alu_op;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_model(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic [7:0]  op);
        case (op)
            8'd0:    return a + b;
            8'd2:    return a - b;
            8'd12:   return a << b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    always_comb begin
        rr_alu_c    = alu_model(rr_alu_a, rr_alu_b, rr_alu_op);
        rr_alu_zero = (rr_alu_c == 32'd0);
        rr_alu_neg  = rr_alu_c[31];
        fp_alu_c    = alu_model(fp_alu_a, fp_alu_b, fp_alu_op);
        fp_alu_zero = (fp_alu_c == 32'd0);
        fp_alu_neg  = fp_alu_c[31];
    end

    alu_arbiter #(.RR(1'b1)) u_rr (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(rr_req0_ready), .req1_ready(rr_req1_ready),
        .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
        .req0_op(req0_op), .req1_op(req1_op),
        .rsp0_valid(rr_rsp0_valid), .rsp1_valid(rr_rsp1_valid),
        .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
        .rsp_c(rr_rsp_c), .rsp_zero(rr_rsp_zero), .rsp_neg(rr_rsp_neg),
        .alu_a(rr_alu_a), .alu_b(rr_alu_b), .alu_op(rr_alu_op),
        .alu_c(rr_alu_c), .alu_zero(rr_alu_zero), .alu_neg(rr_alu_neg)
    );

    alu_arbiter #(.RR(1'b0)) u_fp (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(fp_req0_ready), .req1_ready(fp_req1_ready),
        .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
        .req0_op(req0_op), .req1_op(req1_op),
        .rsp0_valid(fp_rsp0_valid), .rsp1_valid(fp_rsp1_valid),
        .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
        .rsp_c(fp_rsp_c), .rsp_zero(fp_rsp_zero), .rsp_neg(fp_rsp_neg),
        .alu_a(fp_alu_a), .alu_b(fp_alu_b), .alu_op(fp_alu_op),
        .alu_c(fp_alu_c), .alu_zero(fp_alu_zero), .alu_neg(fp_alu_neg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven there
    // and outputs are checked one time unit later.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k0, k1, own;
        logic e0, e1;

        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;

        // Reset state
        nxt(); nxt();
        req0_valid = 1'b1; #1;
        chk("rst_req0_ready", rr_req0_ready, 0);
        chk("rst_rsp0_valid", rr_rsp0_valid, 0);
        chk("rst_rsp1_valid", rr_rsp1_valid, 0);
        chk("rst_alu_a",      rr_alu_a, 0);
        chk("rst_rsp_c",      rr_rsp_c, 0);
        $display("reset state checked");

        // Single op on port 0: 5 + 7
        nxt();
        reset = 1'b0; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_op = 8'd0; #1;
        chk("single_req0_ready", rr_req0_ready, 1);
        nxt(); req0_valid = 1'b0; #1;
        chk("single_s1_rsp0", rr_rsp0_valid, 0);
        chk("single_alu_a", rr_alu_a, 5);
        chk("single_alu_b", rr_alu_b, 7);
        nxt(); #1;
        chk("single_rsp0_valid", rr_rsp0_valid, 1);
        chk("single_rsp1_valid", rr_rsp1_valid, 0);
        chk("single_rsp_c", rr_rsp_c, 12);
        chk("single_zero", rr_rsp_zero, 0);
        chk("single_neg", rr_rsp_neg, 0);
        nxt(); #1;
        chk("single_drained", rr_rsp0_valid, 0);
        chk("single_c_hold", rr_rsp_c, 12);
        $display("single op 5+7 checked");

        // Flags on port 1: 5-5 then 3-5
        nxt();
        req1_valid = 1'b1; req1_a = 32'd5; req1_b = 32'd5; req1_op = 8'd2; #1;
        chk("flag_req1_ready0", rr_req1_ready, 1);
        nxt(); req1_a = 32'd3; #1;
        chk("flag_req1_ready1", rr_req1_ready, 1);
        nxt(); req1_valid = 1'b0; #1;
        chk("flag_rsp1_valid0", rr_rsp1_valid, 1);
        chk("flag_rsp0_valid0", rr_rsp0_valid, 0);
        chk("flag_c0", rr_rsp_c, 0);
        chk("flag_zero0", rr_rsp_zero, 1);
        chk("flag_neg0", rr_rsp_neg, 0);
        nxt(); #1;
        chk("flag_rsp1_valid1", rr_rsp1_valid, 1);
        chk("flag_c1", rr_rsp_c, 32'hFFFF_FFFE);
        chk("flag_zero1", rr_rsp_zero, 0);
        chk("flag_neg1", rr_rsp_neg, 1);
        nxt(); #1;
        chk("flag_drained", rr_rsp1_valid, 0);
        $display("flags zero/neg checked");

        // Round-robin streaming, 4 ops per port
        k0 = 0; k1 = 0;
        for (int i = 0; i < 10; i++) begin
            nxt();
            req0_valid = (k0 < 4); req0_a = 32'(100 + k0); req0_b = 32'd1; req0_op = 8'd0;
            req1_valid = (k1 < 4); req1_a = 32'(200 + k1); req1_b = 32'd1; req1_op = 8'd0;
            #1;
            e0 = (i < 8) && (i % 2 == 0);
            e1 = (i < 8) && (i % 2 == 1);
            chk("rr_req0_ready", rr_req0_ready, 32'(e0));
            chk("rr_req1_ready", rr_req1_ready, 32'(e1));
            if (i >= 2) begin
                own = (i - 2) % 2;
                chk("rr_rsp0_valid", rr_rsp0_valid, 32'(own == 0));
                chk("rr_rsp1_valid", rr_rsp1_valid, 32'(own == 1));
                chk("rr_rsp_c", rr_rsp_c, 32'((own == 1 ? 200 : 100) + (i - 2) / 2 + 1));
            end else begin
                chk("rr_rsp0_idle", rr_rsp0_valid, 0);
                chk("rr_rsp1_idle", rr_rsp1_valid, 0);
            end
            if (e0) k0++;
            if (e1) k1++;
            $display("rr cycle %0d ready0=%0d ready1=%0d rsp_c=%0d", i, rr_req0_ready, rr_req1_ready, rr_rsp_c);
        end
        nxt(); #1;
        chk("rr_done0", rr_rsp0_valid, 0);
        chk("rr_done1", rr_rsp1_valid, 0);

        // Back-pressure: port 0 shl result held while port 1 streams
        nxt();
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd4; req0_op = 8'd12;
        req1_valid = 1'b1; req1_a = 32'd300; req1_b = 32'd1; req1_op = 8'd0; #1;
        chk("bp_req0_ready", rr_req0_ready, 1);
        chk("bp_req1_wait", rr_req1_ready, 0);
        nxt(); req0_valid = 1'b0; #1;
        chk("bp_req1_ready", rr_req1_ready, 1);
        nxt(); req1_a = 32'd301; #1;
        chk("bp_hold_valid_a", rr_rsp0_valid, 1);
        chk("bp_hold_c_a", rr_rsp_c, 16);
        chk("bp_refuse_a", rr_req1_ready, 0);
        chk("bp_no_rsp1_a", rr_rsp1_valid, 0);
        nxt(); #1;
        chk("bp_hold_valid_b", rr_rsp0_valid, 1);
        chk("bp_hold_c_b", rr_rsp_c, 16);
        chk("bp_refuse_b", rr_req1_ready, 0);
        nxt(); rsp0_ready = 1'b1; #1;
        chk("bp_release_valid", rr_rsp0_valid, 1);
        chk("bp_release_c", rr_rsp_c, 16);
        chk("bp_resume_ready", rr_req1_ready, 1);
        nxt(); req1_valid = 1'b0; #1;
        chk("bp_p1_first_valid", rr_rsp1_valid, 1);
        chk("bp_p1_first_c", rr_rsp_c, 301);
        chk("bp_p0_gone", rr_rsp0_valid, 0);
        nxt(); #1;
        chk("bp_p1_second_valid", rr_rsp1_valid, 1);
        chk("bp_p1_second_c", rr_rsp_c, 302);
        nxt(); #1;
        chk("bp_empty", rr_rsp1_valid, 0);
        $display("back-pressure hold/resume checked");

        // Reset with S1 and S2 both full
        nxt();
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd1; req0_op = 8'd0; #1;
        chk("mid_acc0", rr_req0_ready, 1);
        nxt(); req0_a = 32'd8; #1;
        chk("mid_acc1", rr_req0_ready, 1);
        nxt(); req0_a = 32'd9; #1;
        chk("mid_full_rsp0", rr_rsp0_valid, 1);
        chk("mid_full_c", rr_rsp_c, 8);
        chk("mid_full_refuse", rr_req0_ready, 0);
        nxt(); reset = 1'b1; req1_valid = 1'b1; #1;
        chk("mid_rst_ready0", rr_req0_ready, 0);
        chk("mid_rst_ready1", rr_req1_ready, 0);
        nxt(); #1;
        chk("mid_rst_rsp0", rr_rsp0_valid, 0);
        chk("mid_rst_rsp1", rr_rsp1_valid, 0);
        chk("mid_rst_c", rr_rsp_c, 0);
        chk("mid_rst_alu_a", rr_alu_a, 0);
        nxt();
        reset = 1'b0; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_a = 32'd20; req0_b = 32'd1; req0_op = 8'd0;
        req1_a = 32'd40; req1_b = 32'd1; req1_op = 8'd0; #1;
        chk("post_rst_req0", rr_req0_ready, 1);
        chk("post_rst_req1", rr_req1_ready, 0);
        nxt(); req0_valid = 1'b0; #1;
        chk("post_rst_req1_next", rr_req1_ready, 1);
        nxt(); req1_valid = 1'b0; #1;
        chk("post_rst_rsp0", rr_rsp0_valid, 1);
        chk("post_rst_c0", rr_rsp_c, 21);
        nxt(); #1;
        chk("post_rst_rsp1", rr_rsp1_valid, 1);
        chk("post_rst_c1", rr_rsp_c, 41);
        $display("reset mid-flight checked");

        // Fixed priority: port 0 takes every grant while valid
        nxt(); reset = 1'b1; #1;
        nxt();
        reset = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd50; req0_b = 32'd1; req0_op = 8'd0;
        req1_valid = 1'b1; req1_a = 32'd60; req1_b = 32'd1; req1_op = 8'd0; #1;
        for (int j = 0; j < 4; j++) begin
            chk("fp_req0_ready", fp_req0_ready, 1);
            chk("fp_req1_ready", fp_req1_ready, 0);
            if (j >= 2) begin
                chk("fp_rsp0_valid", fp_rsp0_valid, 1);
                chk("fp_rsp1_valid", fp_rsp1_valid, 0);
                chk("fp_rsp_c", fp_rsp_c, 51);
                chk("fp_rsp_zero", fp_rsp_zero, 0);
                chk("fp_rsp_neg", fp_rsp_neg, 0);
            end
            $display("fp cycle %0d ready0=%0d ready1=%0d", j, fp_req0_ready, fp_req1_ready);
            nxt(); #1;
        end
        req0_valid = 1'b0; #1;
        chk("fp_req1_after_drop", fp_req1_ready, 1);
        nxt(); req1_valid = 1'b0; #1;
        nxt(); nxt();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
